// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen (master) and pixel logic (slave).
// frame_cnt is only present when VGA_TIMING_FRAME_CNT_EN is defined.
// Handshake: pix_ce is a valid-only qualifier with no ready; every clock where
// pix_ce=1 the generator advances one pixel, and the consumer must accept it.
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  logic          pix_ce;
  logic [CW-1:0] h_coord;
  logic [CW-1:0] v_coord;
  logic          h_sync;
  logic          v_sync;
  logic          disp_enbl;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;

  modport master (
    input  pix_ce,
    output h_coord, v_coord, h_sync, v_sync, disp_enbl,
           line_start, frame_start, frame_cnt
  );
  modport slave (
    output pix_ce,
    input  h_coord, v_coord, h_sync, v_sync, disp_enbl,
           line_start, frame_start, frame_cnt
  );
`else
  modport master (
    input  pix_ce,
    output h_coord, v_coord, h_sync, v_sync, disp_enbl,
           line_start, frame_start
  );
  modport slave (
    output pix_ce,
    input  h_coord, v_coord, h_sync, v_sync, disp_enbl,
           line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator. Coordinates are the counter
// registers; sync/DE/strobes are decoded from them and delayed PIPE_STAGES
// enabled cycles to line up with a downstream pixel pipeline.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN for the frame_cnt output.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 24,
  parameter int H_SYNC      = 72,
  parameter int H_BP        = 128,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 22,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int CW          = 11,
  parameter int PIPE_STAGES = 1
) (
  input  logic              pixel_clk,
  input  logic              rst,
  vga_timing_gen_if.master  tmg
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Every boundary below is < H_TOTAL (resp. V_TOTAL) <= 2**CW, so it fits CW bits.
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG    = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG    = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } timing_t;

  // Value every pipeline stage holds after reset: syncs inactive, no DE, no strobes.
  localparam timing_t FLUSH = timing_t'({~HS_POL, ~VS_POL, 3'b000});

  // Reject unusable timing at elaboration.
  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
      $error("vga_timing_gen: horizontal active/porch/sync widths must be >= 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
      $error("vga_timing_gen: vertical active/porch/sync widths must be >= 1");
    end
    if (PIPE_STAGES < 1) begin : g_bad_pipe
      $error("vga_timing_gen: PIPE_STAGES must be >= 1");
    end
    if (CW < 1 || CW > 30 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit in CW bits");
    end
  endgenerate

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  timing_t       dec;
  timing_t       pipe_q [PIPE_STAGES];

  // Raster counters: h wraps each line, v advances on h wrap and wraps each frame.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tmg.pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  // Decode the current position; v_sync follows v only, so it is line-aligned.
  always_comb begin
    dec    = FLUSH;
    dec.de = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    dec.hs = (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
    dec.vs = (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;
    dec.ls = (h_cnt == '0);
    dec.fs = (h_cnt == '0) && (v_cnt == '0);
  end

  // Delay line for decoded timing; shifts only on enabled cycles, so strobes
  // stay up until the next enabled cycle when pix_ce is sparse.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= FLUSH;
    end else if (tmg.pix_ce) begin
      pipe_q[0] <= dec;
      for (int i = 1; i < PIPE_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tmg.h_coord     = h_cnt;
  assign tmg.v_coord     = v_cnt;
  assign tmg.h_sync      = pipe_q[PIPE_STAGES-1].hs;
  assign tmg.v_sync      = pipe_q[PIPE_STAGES-1].vs;
  assign tmg.disp_enbl   = pipe_q[PIPE_STAGES-1].de;
  assign tmg.line_start  = pipe_q[PIPE_STAGES-1].ls;
  assign tmg.frame_start = pipe_q[PIPE_STAGES-1].fs;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Count completed frames on the last pixel of the last line, wrapping at 2**16.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (tmg.pix_ce && h_cnt == H_LAST && v_cnt == V_LAST) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign tmg.frame_cnt = frame_cnt_q;
`endif

endmodule
